mips_cpu_lsu: RTL and testbench

Parametrised load/store unit between the multicycle MIPS core's EXEC/MEM_ACCESS stage and the Avalon memory-mapped bus master port. Takes one memory request per handshake (LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW), drives a word-aligned Avalon read or write with the correct byteenable, and holds it through waitrequest. Load data comes back lane-extracted, sign/zero-extended or LWL/LWR-merged. Endianness and a bus watchdog are selectable by parameter.

---
 rtl/mips_cpu_lsu.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mips_cpu_lsu.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_lsu.sv
// mips_cpu_lsu
// Load/store unit between the multicycle MIPS core's memory stage and an
// Avalon-MM master port. It accepts one request per handshake, runs a single
// word-aligned Avalon read or write, and returns a one-cycle response that
// carries the lane-extracted, sign/zero-extended or LWL/LWR-merged load data.
//
// Handshakes:
//   req_valid/req_ready: a request transfers on a rising clk edge where both
//   are 1. req_ready is 1 only in IDLE. The request fields are captured at that
//   edge, so the requester may change them afterwards. resp_valid is a
//   one-cycle pulse with no back-pressure. The Avalon side holds read/write,
//   address, byteenable and writedata stable while waitrequest is 1, and the
//   transfer completes on the first edge where waitrequest is 0.
//
// Parameters:
//   BIG_ENDIAN : 0 = byte offset o uses lane o, 1 = byte offset o uses lane 3-o
//   TIMEOUT    : maximum waitrequest stall cycles before an error (0 = never)
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_valid/req_ready     request handshake
//   req_op                  0 LB,1 LBU,2 LH,3 LHU,4 LW,5 LWL,6 LWR,8 SB,9 SH,10 SW
//   req_addr                byte address
//   req_wdata, req_rt_old   store data and the old rt value for LWL/LWR
//   resp_valid/rdata/error  completion pulse, load result, error flag
//   address, read, write, waitrequest, writedata, byteenable, readdata
//                           Avalon-MM master signals
//   dbg_state               current FSM state (0 IDLE, 1 BUS, 2 RESP)
module mips_cpu_lsu #(
  parameter int BIG_ENDIAN = 0,
  parameter int TIMEOUT    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt_old,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  // The counter must be able to hold the value TIMEOUT itself; a 1-bit
  // counter is kept when the watchdog is disabled so the logic stays legal.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] stall_cnt;
  logic [3:0]    op_q;
  logic [1:0]    off_q;
  logic [31:0]   rt_old_q;

  assign req_ready = (state == S_IDLE);
  assign dbg_state = state;

  // ---------------------------------------------------------------------
  // Decode of the incoming request (used only on the accept edge)
  // ---------------------------------------------------------------------
  logic [1:0]  off_in;
  logic [1:0]  lane_in;
  logic [1:0]  half_in;
  logic        in_load;
  logic        in_store;
  logic        in_legal;
  logic        in_misaligned;
  logic [3:0]  be_in;
  logic [31:0] wd_in;

  always_comb begin
    off_in  = req_addr[1:0];
    lane_in = (BIG_ENDIAN != 0) ? (2'd3 - off_in) : off_in;
    // Only meaningful for even offsets; odd offsets are rejected for halfwords.
    half_in = (BIG_ENDIAN != 0) ? (2'd2 - off_in) : off_in;

    in_load  = 1'b0;
    in_store = 1'b0;
    case (req_op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR: in_load  = 1'b1;
      OP_SB, OP_SH, OP_SW:                                  in_store = 1'b1;
      default: ;
    endcase
    in_legal = in_load | in_store;

    in_misaligned = 1'b0;
    case (req_op)
      OP_LH, OP_LHU, OP_SH: in_misaligned = off_in[0];
      OP_LW, OP_SW:         in_misaligned = (off_in != 2'd0);
      default: ;
    endcase

    be_in = 4'b1111;
    wd_in = 32'h0;
    case (req_op)
      OP_SB: begin
        be_in = 4'b0001 << lane_in;
        wd_in = {4{req_wdata[7:0]}};
      end
      OP_SH: begin
        be_in = 4'b0011 << half_in;
        wd_in = {2{req_wdata[15:0]}};
      end
      OP_SW: begin
        be_in = 4'b1111;
        wd_in = req_wdata;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Load result formatting from the registered request and bus readdata
  // ---------------------------------------------------------------------
  logic [1:0]  lane_q;
  logic [1:0]  half_q;
  logic [1:0]  merge_q;
  logic [4:0]  lane_sh;
  logic [4:0]  half_sh;
  logic [4:0]  lwl_sh;
  logic [4:0]  lwr_sh;
  logic [31:0] byte_word;
  logic [31:0] half_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_result;
  logic        q_is_load;

  always_comb begin
    lane_q  = (BIG_ENDIAN != 0) ? (2'd3 - off_q) : off_q;
    half_q  = (BIG_ENDIAN != 0) ? (2'd2 - off_q) : off_q;
    merge_q = (BIG_ENDIAN != 0) ? off_q : (2'd3 - off_q);
    lane_sh = {lane_q, 3'b000};
    half_sh = {half_q, 3'b000};
    lwl_sh  = {merge_q, 3'b000};
    lwr_sh  = {2'd3 - merge_q, 3'b000};

    byte_word = readdata >> lane_sh;
    half_word = readdata >> half_sh;
    ld_byte   = byte_word[7:0];
    ld_half   = half_word[15:0];

    q_is_load = (op_q[3] == 1'b0);

    load_result = 32'h0;
    case (op_q)
      OP_LB:  load_result = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU: load_result = {24'h0, ld_byte};
      OP_LH:  load_result = {{16{ld_half[15]}}, ld_half};
      OP_LHU: load_result = {16'h0, ld_half};
      OP_LW:  load_result = readdata;
      // LWL fills the upper bytes from memory and keeps the low bytes of rt.
      OP_LWL: load_result = (readdata << lwl_sh) |
                            (rt_old_q & ((32'h1 << lwl_sh) - 32'h1));
      // LWR fills the lower bytes from memory and keeps the high bytes of rt.
      OP_LWR: load_result = (readdata >> lwr_sh) |
                            (rt_old_q & ~(32'hFFFF_FFFF >> lwr_sh));
      default: load_result = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      stall_cnt  <= '0;
      op_q       <= 4'h0;
      off_q      <= 2'b00;
      rt_old_q   <= 32'h0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= 32'h0;
      byteenable <= 4'h0;
      writedata  <= 32'h0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            op_q     <= req_op;
            off_q    <= req_addr[1:0];
            rt_old_q <= req_rt_old;
            if (!in_legal || in_misaligned) begin
              // Rejected without touching the bus.
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              state      <= S_BUS;
              stall_cnt  <= '0;
              address    <= {req_addr[31:2], 2'b00};
              byteenable <= be_in;
              writedata  <= wd_in;
              read       <= in_load;
              write      <= in_store;
            end
          end
        end

        S_BUS: begin
          if (!waitrequest) begin
            read       <= 1'b0;
            write      <= 1'b0;
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= q_is_load ? load_result : 32'h0;
          end else begin
            stall_cnt <= stall_cnt + CW'(1);
            // The counter reaches TIMEOUT on this edge: abandon the transfer.
            if ((TIMEOUT > 0) && (stall_cnt == TO_LAST)) begin
              read       <= 1'b0;
              write      <= 1'b0;
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'h0;
            end
          end
        end

        S_RESP: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          read       <= 1'b0;
          write      <= 1'b0;
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Bench for mips_cpu_lsu. Two instances share all inputs: a little-endian one
// with a 4-cycle watchdog and a big-endian one without a watchdog. sel picks
// which instance's outputs are observed and steer the waitrequest pattern.
module tb_mips_cpu_lsu;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_rt_old, readdata;
  logic        waitrequest;

  logic        le_req_ready, le_resp_valid, le_resp_error, le_read, le_write;
  logic [31:0] le_resp_rdata, le_address, le_writedata;
  logic [3:0]  le_byteenable;
  logic [1:0]  le_state;
  logic        be_req_ready, be_resp_valid, be_resp_error, be_read, be_write;
  logic [31:0] be_resp_rdata, be_address, be_writedata;
  logic [3:0]  be_byteenable;
  logic [1:0]  be_state;

  mips_cpu_lsu #(.BIG_ENDIAN(0), .TIMEOUT(4)) dut_le (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(le_req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rt_old(req_rt_old), .resp_valid(le_resp_valid),
    .resp_rdata(le_resp_rdata), .resp_error(le_resp_error),
    .address(le_address), .read(le_read), .write(le_write),
    .waitrequest(waitrequest), .writedata(le_writedata),
    .byteenable(le_byteenable), .readdata(readdata), .dbg_state(le_state)
  );

  mips_cpu_lsu #(.BIG_ENDIAN(1), .TIMEOUT(0)) dut_be (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(be_req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rt_old(req_rt_old), .resp_valid(be_resp_valid),
    .resp_rdata(be_resp_rdata), .resp_error(be_resp_error),
    .address(be_address), .read(be_read), .write(be_write),
    .waitrequest(waitrequest), .writedata(be_writedata),
    .byteenable(be_byteenable), .readdata(readdata), .dbg_state(be_state)
  );

  logic        sel;
  logic        m_req_ready, m_resp_valid, m_resp_error, m_read, m_write;
  logic [31:0] m_resp_rdata, m_address, m_writedata;
  logic [3:0]  m_byteenable;
  assign m_req_ready  = sel ? be_req_ready  : le_req_ready;
  assign m_resp_valid = sel ? be_resp_valid : le_resp_valid;
  assign m_resp_error = sel ? be_resp_error : le_resp_error;
  assign m_resp_rdata = sel ? be_resp_rdata : le_resp_rdata;
  assign m_read       = sel ? be_read       : le_read;
  assign m_write      = sel ? be_write      : le_write;
  assign m_address    = sel ? be_address    : le_address;
  assign m_writedata  = sel ? be_writedata  : le_writedata;
  assign m_byteenable = sel ? be_byteenable : le_byteenable;

  // ---------------- scoreboard counters ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        sel;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rt;
    logic [31:0] rd;
    int          stalls;     // waitrequest=1 cycles before completion
    int          n_strobe;   // expected strobe cycles (0 = no bus cycle)
    int          lat;        // expected resp_valid cycle after accept
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string name, input logic s, input logic [3:0] op,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rt, input logic [31:0] rd,
                     input int stalls, input int n_strobe, input int lat,
                     input logic err, input logic [31:0] exp_rdata,
                     input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    vec_t v;
    v.name = name; v.sel = s; v.op = op; v.addr = addr; v.wdata = wdata;
    v.rt = rt; v.rd = rd; v.stalls = stalls; v.n_strobe = n_strobe;
    v.lat = lat; v.exp_err = err; v.exp_rdata = exp_rdata;
    v.exp_be = exp_be; v.exp_wdata = exp_wdata;
    vq.push_back(v);
  endtask

  // Drives one request through accept, the bus phase and the response,
  // then checks the cycle after the response.
  task automatic run_req(input vec_t v);
    int cyc, strobe_n, rd_n, wr_n, lat;
    logic got, both, ready_busy, err;
    logic [31:0] rdata, addr_seen, wd_seen;
    logic [3:0]  be_seen;
    logic        is_load;
    is_load = (v.op[3] == 1'b0);
    sel = v.sel;
    req_op = v.op; req_addr = v.addr; req_wdata = v.wdata; req_rt_old = v.rt;
    readdata = v.rd; waitrequest = 1'b1; req_valid = 1'b1;
    check32({v.name, " ready_before"}, {31'h0, m_req_ready}, 32'h1);
    cyc = 0; strobe_n = 0; rd_n = 0; wr_n = 0; lat = -1;
    got = 1'b0; both = 1'b0; ready_busy = 1'b0; err = 1'b0;
    rdata = 32'h0; addr_seen = 32'h0; wd_seen = 32'h0; be_seen = 4'h0;
    while (!got && cyc < 40) begin
      tick();
      cyc++;
      // The unit must have registered the request; scramble the inputs.
      req_valid = 1'b0;
      req_op = 4'($urandom_range(0, 15));
      req_addr = $urandom; req_wdata = $urandom; req_rt_old = $urandom;
      if (m_read && m_write) both = 1'b1;
      if (m_read || m_write) begin
        strobe_n++;
        if (m_read) rd_n++;
        if (m_write) wr_n++;
        if (m_req_ready) ready_busy = 1'b1;
        be_seen = m_byteenable; addr_seen = m_address; wd_seen = m_writedata;
        waitrequest = (strobe_n <= v.stalls);
      end
      if (m_resp_valid) begin
        got = 1'b1; lat = cyc; rdata = m_resp_rdata; err = m_resp_error;
      end
    end
    check32({v.name, " latency"}, lat, v.lat);
    check32({v.name, " resp_error"}, {31'h0, err}, {31'h0, v.exp_err});
    check32({v.name, " resp_rdata"}, rdata, v.exp_rdata);
    check32({v.name, " read_cycles"}, rd_n, is_load ? v.n_strobe : 0);
    check32({v.name, " write_cycles"}, wr_n, is_load ? 0 : v.n_strobe);
    check32({v.name, " rd_wr_overlap"}, {31'h0, both}, 32'h0);
    check32({v.name, " ready_while_busy"}, {31'h0, ready_busy}, 32'h0);
    if (v.n_strobe > 0) begin
      check32({v.name, " address"}, addr_seen, {v.addr[31:2], 2'b00});
      check32({v.name, " byteenable"}, {28'h0, be_seen}, {28'h0, v.exp_be});
      if (!is_load) check32({v.name, " writedata"}, wd_seen, v.exp_wdata);
    end
    tick();
    waitrequest = 1'b1;
    check32({v.name, " pulse_one_cycle"}, {31'h0, m_resp_valid}, 32'h0);
    check32({v.name, " rdata_held"}, m_resp_rdata, v.exp_rdata);
    check32({v.name, " ready_after"}, {31'h0, m_req_ready}, 32'h1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int resp_seen;
    reset = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_addr = 32'h0;
    req_wdata = 32'h0; req_rt_old = 32'h0; readdata = 32'h0;
    waitrequest = 1'b1; sel = 1'b0;
    repeat (3) tick();

    // Reset values of both instances
    check32("reset_le_ctrl",
            {24'h0, le_req_ready, le_read, le_write, le_resp_valid, le_resp_error, 1'b0, le_state},
            {24'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
    check32("reset_le_rdata", le_resp_rdata, 32'h0);
    check32("reset_le_addr", le_address, 32'h0);
    check32("reset_le_wdata", le_writedata, 32'h0);
    check32("reset_le_be", {28'h0, le_byteenable}, 32'h0);
    check32("reset_be_ctrl",
            {24'h0, be_req_ready, be_read, be_write, be_resp_valid, be_resp_error, 1'b0, be_state},
            {24'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
    check32("reset_be_bus", be_address | be_writedata | {28'h0, be_byteenable} | be_resp_rdata, 32'h0);
    reset = 1'b0;
    tick();

    //   name       sel op      addr          wdata         rt            readdata      st str lat err rdata         be       wdata
    add("le_lb",    0, OP_LB,  32'h0000_1003, 32'h0,        32'h0,        32'h80FF_0000, 0, 1, 2, 0, 32'hFFFF_FF80, 4'b1111, 32'h0);
    add("be_sh",    1, OP_SH,  32'h0000_2002, 32'h0000_BEEF, 32'h0,       32'h0,         3, 4, 5, 0, 32'h0,        4'b0011, 32'hBEEF_BEEF);
    add("le_lwl",   0, OP_LWL, 32'h0000_3001, 32'h0,        32'h1122_3344, 32'hAABB_CCDD, 0, 1, 2, 0, 32'hCCDD_3344, 4'b1111, 32'h0);
    add("le_lwr",   0, OP_LWR, 32'h0000_3001, 32'h0,        32'h1122_3344, 32'hAABB_CCDD, 0, 1, 2, 0, 32'h11AA_BBCC, 4'b1111, 32'h0);
    add("le_lw_mis",0, OP_LW,  32'h0000_4002, 32'h0,        32'h0,        32'h1234_5678, 0, 0, 1, 1, 32'h0,        4'b0000, 32'h0);
    add("le_lbu",   0, OP_LBU, 32'h0000_1001, 32'h0,        32'h0,        32'h1234_8056, 0, 1, 2, 0, 32'h0000_0080, 4'b1111, 32'h0);
    add("be_lb",    1, OP_LB,  32'h0000_1001, 32'h0,        32'h0,        32'h1234_8056, 1, 2, 3, 0, 32'h0000_0034, 4'b1111, 32'h0);
    add("le_lh",    0, OP_LH,  32'h0000_1002, 32'h0,        32'h0,        32'h8001_7FFF, 0, 1, 2, 0, 32'hFFFF_8001, 4'b1111, 32'h0);
    add("be_lhu",   1, OP_LHU, 32'h0000_1000, 32'h0,        32'h0,        32'h8001_7FFF, 0, 1, 2, 0, 32'h0000_8001, 4'b1111, 32'h0);
    add("le_sb",    0, OP_SB,  32'h0000_5002, 32'h1234_56A5, 32'h0,       32'hFFFF_FFFF, 0, 1, 2, 0, 32'h0,        4'b0100, 32'hA5A5_A5A5);
    add("be_sb",    1, OP_SB,  32'h0000_5000, 32'h0000_00C3, 32'h0,       32'h0,         1, 2, 3, 0, 32'h0,        4'b1000, 32'hC3C3_C3C3);
    add("le_sw",    0, OP_SW,  32'h0000_6000, 32'hDEAD_BEEF, 32'h0,       32'h0,         2, 3, 4, 0, 32'h0,        4'b1111, 32'hDEAD_BEEF);
    add("le_sh_mis",0, OP_SH,  32'h0000_6001, 32'hFFFF_FFFF, 32'h0,       32'h0,         0, 0, 1, 1, 32'h0,        4'b0000, 32'h0);
    add("le_ill7",  0, 4'd7,   32'h0000_7000, 32'h0,        32'h0,        32'hFFFF_FFFF, 0, 0, 1, 1, 32'h0,        4'b0000, 32'h0);
    add("be_lwl",   1, OP_LWL, 32'h0000_3001, 32'h0,        32'h1122_3344, 32'hAABB_CCDD, 0, 1, 2, 0, 32'hBBCC_DD44, 4'b1111, 32'h0);
    add("be_lwr",   1, OP_LWR, 32'h0000_3002, 32'h0,        32'h1122_3344, 32'hAABB_CCDD, 0, 1, 2, 0, 32'h11AA_BBCC, 4'b1111, 32'h0);
    add("le_lwl3",  0, OP_LWL, 32'h0000_3003, 32'h0,        32'h1122_3344, 32'hAABB_CCDD, 0, 1, 2, 0, 32'hAABB_CCDD, 4'b1111, 32'h0);
    add("le_lwr0",  0, OP_LWR, 32'h0000_3000, 32'h0,        32'h1122_3344, 32'hAABB_CCDD, 0, 1, 2, 0, 32'hAABB_CCDD, 4'b1111, 32'h0);
    add("le_lw",    0, OP_LW,  32'h0000_4000, 32'h0,        32'h0,        32'h1357_9BDF, 0, 1, 2, 0, 32'h1357_9BDF, 4'b1111, 32'h0);
    add("le_ill15", 0, 4'd15,  32'h0000_4000, 32'h0,        32'h0,        32'h1357_9BDF, 0, 0, 1, 1, 32'h0,        4'b0000, 32'h0);
    add("le_lhu_mis",0,OP_LHU, 32'h0000_1003, 32'h0,        32'h0,        32'h1357_9BDF, 0, 0, 1, 1, 32'h0,        4'b0000, 32'h0);
    // Watchdog (LE instance, TIMEOUT=4): waitrequest never drops. Kept last
    // because the big-endian instance stays stalled until the reset below.
    add("le_timeout",0,OP_LW,  32'h0000_8000, 32'h0,        32'h0,        32'h0,      1000, 4, 5, 1, 32'h0,        4'b1111, 32'h0);

    foreach (vq[i]) run_req(vq[i]);

    // Reset during a second stalled read: strobe drops, no response follows.
    sel = 1'b0;
    waitrequest = 1'b1;
    req_op = OP_LW; req_addr = 32'h0000_8004; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check32("rst_mid read_cycle1", {31'h0, le_read}, 32'h1);
    tick();
    check32("rst_mid read_cycle2", {31'h0, le_read}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check32("rst_mid read_dropped", {31'h0, le_read}, 32'h0);
    check32("rst_mid ready", {31'h0, le_req_ready}, 32'h1);
    check32("rst_mid be_inst_read", {31'h0, be_read}, 32'h0);
    resp_seen = 0;
    repeat (8) begin
      if (le_resp_valid || le_read || be_resp_valid) resp_seen++;
      tick();
    end
    check32("rst_mid no_response", resp_seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
